// File: rtl/rvx_core_div_ctrl_pkg.sv
// Shared constants and helpers for the RV32M iterative divide unit.
// Holds the M-extension divide funct3 codes and the conditional-negate helper.
package rvx_core_div_ctrl_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] RISCV_FUNCT3_DIV  = 3'b100;
   localparam logic [2:0] RISCV_FUNCT3_DIVU = 3'b101;
   localparam logic [2:0] RISCV_FUNCT3_REM  = 3'b110;
   localparam logic [2:0] RISCV_FUNCT3_REMU = 3'b111;

   // Two's-complement negate when neg is set; used for magnitudes and final sign fix-up.
   function automatic logic [XLEN-1:0] f_cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (XLEN'(0) - v) : v;
   endfunction

endpackage

// File: rtl/rvx_core_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// The shifted partial remainder needs 33 bits because the divisor may use all 32.
module rvx_core_div_step
   import rvx_core_div_ctrl_pkg::*;
(
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   logic [XLEN:0]   w_shift;
   logic [XLEN+1:0] w_diff;
   logic            w_borrow;

   assign w_shift  = {i_rem, i_quo[XLEN-1]};
   assign w_diff   = {1'b0, w_shift} - {2'b00, i_divisor};
   assign w_borrow = w_diff[XLEN+1];

   assign o_rem = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
   assign o_quo = {i_quo[XLEN-2:0], ~w_borrow};

endmodule

// File: rtl/rvx_core_div_ctrl.sv
// Stage-2 iterative divider for DIV/DIVU/REM/REMU: 32 restoring steps on magnitudes,
// with divide-by-zero and signed overflow resolved in a single cycle.
module rvx_core_div_ctrl
   import rvx_core_div_ctrl_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            div_start_s2,
   input  logic [2:0]      funct3_s2,
   input  logic [XLEN-1:0] rs1_data_s2,
   input  logic [XLEN-1:0] rs2_data_s2,
   input  logic            div_kill_s2,
   output logic            div_stall_s2,
   output logic            div_busy_s2,
   output logic            div_valid_s2,
   output logic [XLEN-1:0] div_result_s2
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [4:0]      r_cnt;
   logic            r_is_rem;
   logic            r_neg_q;
   logic            r_neg_r;
   logic [XLEN-1:0] r_dvsr;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic            r_busy;
   logic            r_valid;
   logic [XLEN-1:0] r_result;

   logic [1:0]      w_op;
   logic            w_signed;
   logic            w_accept;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic [XLEN-1:0] w_spec_res;
   logic [XLEN-1:0] w_step_rem;
   logic [XLEN-1:0] w_step_quo;
   logic [XLEN-1:0] w_fin_res;
   logic            w_last;

   // Non-1xx funct3 decodes as DIV (signed quotient).
   assign w_op       = funct3_s2[2] ? funct3_s2[1:0] : 2'b00;
   assign w_signed   = ~w_op[0];
   assign w_accept   = div_start_s2 & ~div_kill_s2;
   assign w_div_zero = (rs2_data_s2 == '0);
   assign w_ovf      = w_signed & (rs1_data_s2 == 32'h8000_0000) & (rs2_data_s2 == '1);
   assign w_special  = w_div_zero | w_ovf;
   assign w_abs_a    = f_cond_neg(rs1_data_s2, w_signed & rs1_data_s2[XLEN-1]);
   assign w_abs_b    = f_cond_neg(rs2_data_s2, w_signed & rs2_data_s2[XLEN-1]);
   assign w_spec_res = w_div_zero ? (w_op[1] ? rs1_data_s2 : '1)
                                  : (w_op[1] ? '0 : 32'h8000_0000);
   assign w_last     = (r_cnt == 5'd31);

   rvx_core_div_step u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_dvsr),
      .o_rem     (w_step_rem),
      .o_quo     (w_step_quo)
   );

   assign w_fin_res = r_is_rem ? f_cond_neg(w_step_rem, r_neg_r)
                               : f_cond_neg(w_step_quo, r_neg_q);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = w_special ? ST_DONE : ST_BUSY;
         ST_BUSY: if (w_last)   w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      if (div_kill_s2) w_next = ST_IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dvsr   <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != ST_IDLE);
         r_valid <= (w_next == ST_DONE);
         if (r_state == ST_IDLE && w_accept) begin
            r_is_rem <= w_op[1];
            r_neg_q  <= w_signed & (rs1_data_s2[XLEN-1] ^ rs2_data_s2[XLEN-1]);
            r_neg_r  <= w_signed & rs1_data_s2[XLEN-1];
            r_dvsr   <= w_abs_b;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_cnt    <= '0;
            if (w_special) r_result <= w_spec_res;
         end else if (r_state == ST_BUSY && !div_kill_s2) begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) r_result <= w_fin_res;
         end
      end
   end

   assign div_stall_s2  = div_start_s2 & ~r_valid;
   assign div_busy_s2   = r_busy;
   assign div_valid_s2  = r_valid;
   assign div_result_s2 = r_result;

endmodule
